// File: rtl/fsm_transition_monitor.sv
// rtl/fsm_transition_monitor.sv - legal-transition, stall and alarm monitor for a 4-state control FSM
module fsm_transition_monitor #(
  parameter int         CNT_W      = 4,
  parameter int         DWELL_W    = 8,
  parameter int         STALL_LIM  = 16,
  parameter logic [3:0] STALL_MASK = 4'b1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         state_in,
  input  logic               alarm_clr,
  output logic               alarm,
  output logic               viol_pulse,
  output logic               stall,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic [DWELL_W-1:0] dwell,
  output logic [1:0]         bad_from,
  output logic [1:0]         bad_to
);

  typedef enum logic [1:0] {
    MODE_ARM   = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_ALARM = 2'b10
  } mode_e;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] LIM       = DWELL_W'(STALL_LIM);

  mode_e              mode_q;
  logic [1:0]         prev_q;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               stall_q, stall_d;
  logic               viol_pulse_q, viol_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cap_valid_q;
  logic [1:0]         bad_from_q, bad_to_q;
  logic               trigger;

  // Self-loops are always legal; S1 has no legal exit.
  function automatic logic is_legal(input logic [1:0] from, input logic [1:0] to);
    logic ok;
    ok = 1'b0;
    if (from == to) begin
      ok = 1'b1;
    end else begin
      case (from)
        2'b00:   ok = (to == 2'b01) || (to == 2'b10);
        2'b01:   ok = 1'b0;
        2'b10:   ok = (to == 2'b01) || (to == 2'b11);
        default: ok = (to == 2'b10);
      endcase
    end
    return ok;
  endfunction

  always_comb begin
    viol_d  = 1'b0;
    dwell_d = '0;
    if (mode_q == MODE_ARM) begin
      viol_d = (state_in != 2'b00);
    end else begin
      viol_d = !is_legal(prev_q, state_in);
      if (state_in == prev_q) begin
        dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
      end
    end
    stall_d = STALL_MASK[state_in] && (dwell_d >= LIM);
    trigger = viol_d || (stall_d && !stall_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q       <= MODE_ARM;
      prev_q       <= 2'b00;
      dwell_q      <= '0;
      stall_q      <= 1'b0;
      viol_pulse_q <= 1'b0;
      cnt_q        <= '0;
      cap_valid_q  <= 1'b0;
      bad_from_q   <= 2'b00;
      bad_to_q     <= 2'b00;
    end else begin
      prev_q       <= state_in;
      dwell_q      <= dwell_d;
      stall_q      <= stall_d;
      viol_pulse_q <= viol_d;
      if (viol_d && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (mode_q)
        MODE_ARM:   mode_q <= trigger ? MODE_ALARM : MODE_RUN;
        MODE_RUN:   mode_q <= trigger ? MODE_ALARM : MODE_RUN;
        MODE_ALARM: mode_q <= (trigger || !alarm_clr) ? MODE_ALARM : MODE_RUN;
        default:    mode_q <= MODE_ARM;
      endcase

      // A violation on the clearing edge re-arms the capture with itself.
      if (viol_d && (alarm_clr || !cap_valid_q)) begin
        cap_valid_q <= 1'b1;
        bad_from_q  <= prev_q;
        bad_to_q    <= state_in;
      end else if (alarm_clr) begin
        cap_valid_q <= 1'b0;
        bad_from_q  <= 2'b00;
        bad_to_q    <= 2'b00;
      end
    end
  end

  assign alarm      = (mode_q == MODE_ALARM);
  assign viol_pulse = viol_pulse_q;
  assign stall      = stall_q;
  assign viol_cnt   = cnt_q;
  assign dwell      = dwell_q;
  assign bad_from   = bad_from_q;
  assign bad_to     = bad_to_q;

endmodule
